transmitter: RTL and testbench

Serial transmitter for the team's 32-bit-word UART link. Accepts a 32-bit word over a start/ready handshake and shifts it out on a single line as one frame: start bit, 32 data bits LSB first, one parity bit, one stop bit. Each bit is held for `CLOCK_DIVIDER` clocks, so frames match what the link's receiver expects. It sits on the transmit side of the link, driven by the system controller.

---
 rtl/transmitter.sv | 148 ++++++++++++++
 tb/tb_transmitter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/transmitter.sv
// 32-bit-word UART frame transmitter: start, 32 data bits LSB first, parity, stop.
// Optional one-word holding register enabled by defining TRANSMITTER_HOLD_BUFFER_EN.
module transmitter #(
  parameter int CLOCK_DIVIDER = 10417,
  parameter int BITS_PER_WORD = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_start,
  input  logic [BITS_PER_WORD-1:0] tx_data,
  input  logic                     parity_type,
  output logic                     tx,
  output logic                     tx_ready,
  output logic                     busy,
  output logic                     tx_done
);
  localparam int CNT_W = $clog2(CLOCK_DIVIDER);

  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} state_t;

  state_t                   state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [5:0]               idx, idx_n;
  logic [BITS_PER_WORD-1:0] shift, shift_n, ld_data;
  logic                     par, par_n, tx_n, done_n, ld_pt, load;
  logic                     accept, bit_end;

  // parity_type=1 -> even (^data), 0 -> odd (~^data)
  function automatic logic calc_par(input logic [BITS_PER_WORD-1:0] d, input logic pt);
    return (^d) ^ ~pt;
  endfunction

  assign busy    = (state != IDLE);
  assign bit_end = (cnt == CNT_W'(CLOCK_DIVIDER - 1));
  assign accept  = tx_start && tx_ready;

`ifdef TRANSMITTER_HOLD_BUFFER_EN
  logic                     hold_full, hold_full_n, hold_pt, hold_pt_n;
  logic [BITS_PER_WORD-1:0] hold_data, hold_data_n;
  assign tx_ready = !rst && !hold_full;
`else
  assign tx_ready = !rst && !busy;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par;
    done_n  = 1'b0;
    load    = 1'b0;
    ld_data = tx_data;
    ld_pt   = parity_type;
`ifdef TRANSMITTER_HOLD_BUFFER_EN
    hold_full_n = hold_full;
    hold_data_n = hold_data;
    hold_pt_n   = hold_pt;
`endif
    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;

    case (state)
      IDLE: begin
`ifdef TRANSMITTER_HOLD_BUFFER_EN
        if (hold_full) begin
          load = 1'b1; ld_data = hold_data; ld_pt = hold_pt; hold_full_n = 1'b0;
        end else if (accept) load = 1'b1;
`else
        if (accept) load = 1'b1;
`endif
      end
      START_BIT:  if (bit_end) state_n = DATA_BITS;
      DATA_BITS: if (bit_end) begin
        shift_n = shift >> 1;
        idx_n   = idx + 1'b1;
        if (idx == 6'(BITS_PER_WORD - 1)) state_n = PARITY_BIT;
      end
      PARITY_BIT: if (bit_end) state_n = STOP_BIT;
      STOP_BIT: if (bit_end) begin
        done_n  = 1'b1;
        state_n = IDLE;
`ifdef TRANSMITTER_HOLD_BUFFER_EN
        // back-to-back: skip the idle cycle when a word is waiting
        if (hold_full) begin
          load = 1'b1; ld_data = hold_data; ld_pt = hold_pt; hold_full_n = 1'b0;
        end
`endif
      end
      default: state_n = IDLE;
    endcase

`ifdef TRANSMITTER_HOLD_BUFFER_EN
    if (accept && busy) begin
      hold_full_n = 1'b1; hold_data_n = tx_data; hold_pt_n = parity_type;
    end
`endif

    if (load) begin
      shift_n = ld_data;
      par_n   = calc_par(ld_data, ld_pt);
      cnt_n   = '0;
      idx_n   = '0;
      state_n = START_BIT;
    end

    // line level is registered from the next-state view so it aligns with state
    case (state_n)
      START_BIT:  tx_n = 1'b0;
      DATA_BITS:  tx_n = shift_n[0];
      PARITY_BIT: tx_n = par_n;
      default:    tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      par     <= par_n;
      tx      <= tx_n;
      tx_done <= done_n;
    end
  end

`ifdef TRANSMITTER_HOLD_BUFFER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_pt   <= 1'b0;
    end else begin
      hold_full <= hold_full_n;
      hold_data <= hold_data_n;
      hold_pt   <= hold_pt_n;
    end
  end
`endif
endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter with CLOCK_DIVIDER=16; frames checked bit by bit.
module tb_transmitter;
  localparam int CD = 16;

  logic        clk = 1'b0, rst = 1'b1, tx_start = 1'b0, parity_type = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx, tx_ready, busy, tx_done;
  int          total = 0, bad = 0;

  transmitter #(.CLOCK_DIVIDER(CD), .BITS_PER_WORD(32)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .parity_type(parity_type), .tx(tx), .tx_ready(tx_ready), .busy(busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // accept a word; returns positioned on the first start-bit cycle
  task automatic send(input logic [31:0] d, input logic p);
    tx_data = d; parity_type = p; tx_start = 1'b1;
    step;
    tx_start = 1'b0; tx_data = 32'hDEADBEEF; parity_type = ~p;
  endtask

  // called on the first start-bit cycle; returns on the tx_done cycle
  task automatic check_frame(input string tag, input logic [31:0] d, input logic p, input int inj);
    logic [34:0] fr;
    int txe, be, de;
    txe = 0; be = 0; de = 0;
    fr = {1'b1, p, d, 1'b0};
    for (int k = 0; k < 35*CD; k++) begin
      if (tx !== fr[k/CD]) txe++;
      if (busy !== 1'b1) be++;
      if (tx_done !== 1'b0) de++;
      if (inj >= 0 && k == inj) begin tx_start = 1'b1; tx_data = 32'hFFFFFFFF; end
      if (inj >= 0 && k == inj + 1) begin tx_start = 1'b0; tx_data = '0; end
      step;
    end
    chk({tag, "_bits"}, 32'(txe), 0);
    chk({tag, "_busy"}, 32'(be), 0);
    chk({tag, "_early_done"}, 32'(de), 0);
    chk({tag, "_done"}, 32'(tx_done), 1);
    chk({tag, "_ready"}, 32'(tx_ready), 1);
  endtask

  initial begin
    int hi;
    // reset state
    repeat (3) step;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(tx_ready), 0);
    chk("rst_done", 32'(tx_done), 0);
    rst = 1'b0;
    step;
    chk("idle_ready", 32'(tx_ready), 1);
    chk("idle_tx", 32'(tx), 1);

    // single word, even parity -> parity 1
    send(32'h00000001, 1'b1);
    check_frame("one", 32'h00000001, 1'b1, -1);
    step;
    chk("done_pulse_width", 32'(tx_done), 0);
    chk("idle_after", 32'(busy), 0);

    // 0xA5A5A5A5: 16 ones -> even parity 0, odd parity 1 (back-to-back from done cycle)
    send(32'hA5A5A5A5, 1'b1);
    check_frame("a5_even", 32'hA5A5A5A5, 1'b0, -1);
    send(32'hA5A5A5A5, 1'b0);
    check_frame("a5_odd", 32'hA5A5A5A5, 1'b1, -1);

    // start pulse mid-frame; 0x12345678 has 13 ones -> even parity 1
    send(32'h12345678, 1'b1);
    check_frame("inj", 32'h12345678, 1'b1, 200);
`ifdef TRANSMITTER_HOLD_BUFFER_EN
    chk("held_busy", 32'(busy), 1);
    check_frame("held", 32'hFFFFFFFF, 1'b1, -1);
`else
    hi = 0;
    repeat (50) begin
      step;
      if (tx === 1'b1 && busy === 1'b0) hi++;
    end
    chk("no_queue", 32'(hi), 50);
`endif

    // reset at cycle 200 of a frame (line low there: data bit 11 of 0xF0F0F0F0 is 0)
    step;
    send(32'hF0F0F0F0, 1'b1);
    repeat (200) step;
    chk("pre_rst_tx", 32'(tx), 0);
    rst = 1'b1;
    step;
    chk("midrst_tx", 32'(tx), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(tx_done), 0);
    rst = 1'b0;
    step;
    chk("midrst_no_done", 32'(tx_done), 0);
    send(32'h0F0F0F0F, 1'b0);
    check_frame("after_rst", 32'h0F0F0F0F, 1'b1, -1);
    step;

    // tx_start held: 0x0000FFFF has 16 ones -> even parity 0
    tx_data = 32'h0000FFFF; parity_type = 1'b1; tx_start = 1'b1;
    step;
    check_frame("bb1", 32'h0000FFFF, 1'b0, -1);
    hi = 0;
    while (tx === 1'b1 && hi < 40) begin hi++; step; end
`ifdef TRANSMITTER_HOLD_BUFFER_EN
    chk("gap", 32'(CD + hi), 16);
`else
    chk("gap", 32'(CD + hi), 17);
`endif
    check_frame("bb2", 32'h0000FFFF, 1'b0, -1);
    tx_start = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
